// File: rtl/dual_b_mult_mreg.sv
// Multiplier stage: dual B operand pipeline (B1/B2), signed 25x18 multiply, optional M register.
// Build option DSP_MULT_PARTIAL_PRODUCTS_EN splits the product into two partial terms.
module dual_b_mult_mreg #(
  parameter string B_INPUT  = "DIRECT",
  parameter int    BREG     = 2,
  parameter int    BCASCREG = 1,
  parameter int    MREG     = 1,
  parameter string USE_MULT = "MULTIPLY"
) (
  input  logic        CLK,
  input  logic        RSTB,
  input  logic        RSTM,
  input  logic [17:0] B,
  input  logic [17:0] BCIN,
  input  logic [24:0] A_MULT,
  input  logic        INMODE_4,
  input  logic        CEB1,
  input  logic        CEB2,
  input  logic        CEM,
  output logic [17:0] BCOUT,
  output logic [17:0] X_MUX_B,
  output logic [42:0] M_P0,
  output logic [42:0] M_P1
);

  localparam bit B_CASC  = (B_INPUT == "CASCADE");
  localparam bit B_TWO   = (BREG == 2);
  localparam bit B_NONE  = (BREG == 0);
  localparam bit CASC_B1 = (BREG == 2) && (BCASCREG == 1);
  localparam bit M_ON    = (MREG == 1);
  localparam bit MULT_ON = (USE_MULT == "MULTIPLY");

  if (BREG < 0 || BREG > 2) begin : g_err_breg
    $error("dual_b_mult_mreg: BREG must be 0, 1 or 2");
  end
  if (MREG < 0 || MREG > 1) begin : g_err_mreg
    $error("dual_b_mult_mreg: MREG must be 0 or 1");
  end
  if (BCASCREG < 0 || BCASCREG > 2 || BCASCREG > BREG) begin : g_err_bcasc
    $error("dual_b_mult_mreg: BCASCREG must be 0..2 and not exceed BREG");
  end
  if ((BREG > 0) != (BCASCREG > 0)) begin : g_err_bcasc0
    $error("dual_b_mult_mreg: BCASCREG must be 0 exactly when BREG is 0");
  end
  if (B_INPUT != "DIRECT" && B_INPUT != "CASCADE") begin : g_err_binput
    $error("dual_b_mult_mreg: B_INPUT must be DIRECT or CASCADE");
  end
  if (USE_MULT != "MULTIPLY" && USE_MULT != "NONE") begin : g_err_usemult
    $error("dual_b_mult_mreg: USE_MULT must be MULTIPLY or NONE");
  end

  function automatic logic signed [42:0] mul_full(input logic signed [24:0] a,
                                                  input logic signed [17:0] b);
    logic signed [42:0] ax;
    logic signed [42:0] bx;
    ax = 43'(a);
    bx = 43'(b);
    return ax * bx;
  endfunction

`ifdef DSP_MULT_PARTIAL_PRODUCTS_EN
  // Low term uses B[8:0] as an unsigned magnitude; high term carries the sign of B.
  function automatic logic signed [42:0] mul_lo(input logic signed [24:0] a,
                                                input logic signed [17:0] b);
    logic signed [42:0] ax;
    logic signed [42:0] bx;
    ax = 43'(a);
    bx = 43'($signed({1'b0, b[8:0]}));
    return ax * bx;
  endfunction

  function automatic logic signed [42:0] mul_hi(input logic signed [24:0] a,
                                                input logic signed [17:0] b);
    logic signed [42:0] ax;
    logic signed [42:0] bx;
    ax = 43'(a);
    bx = 43'($signed(b[17:9]));
    return (ax * bx) <<< 9;
  endfunction
`endif

  logic signed [17:0] b_sel;
  logic signed [17:0] b1_q, b1_d;
  logic signed [17:0] b2_q, b2_d;
  logic signed [17:0] b2_w;
  logic signed [17:0] b_mult;
  logic signed [24:0] a_mult;
  logic signed [42:0] prod_p0, prod_p1;
  logic signed [42:0] m_p0_d, m_p1_d;
  logic signed [42:0] m_p0_q, m_p1_q;

  assign b_sel  = B_CASC ? $signed(BCIN) : $signed(B);
  assign a_mult = $signed(A_MULT);

  // Stage B1/B2: operand registers; with BREG=1 only B2 is used, BREG=0 bypasses both.
  assign b1_d = b_sel;
  assign b2_d = B_TWO ? b1_q : b_sel;

  always_ff @(posedge CLK) begin
    if (RSTB) begin
      b1_q <= '0;
      b2_q <= '0;
    end else begin
      if (CEB1) b1_q <= b1_d;
      if (CEB2) b2_q <= b2_d;
    end
  end

  assign b2_w    = B_NONE ? b_sel : b2_q;
  assign X_MUX_B = b2_w;
  assign BCOUT   = CASC_B1 ? b1_q : b2_w;
  assign b_mult  = (B_TWO && INMODE_4) ? b1_q : b2_w;

`ifdef DSP_MULT_PARTIAL_PRODUCTS_EN
  assign prod_p0 = mul_lo(a_mult, b_mult);
  assign prod_p1 = mul_hi(a_mult, b_mult);
`else
  assign prod_p0 = mul_full(a_mult, b_mult);
  assign prod_p1 = '0;
`endif

  assign m_p0_d = MULT_ON ? prod_p0 : '0;
  assign m_p1_d = MULT_ON ? prod_p1 : '0;

  // Stage M: product terms, summed downstream by the ALU.
  always_ff @(posedge CLK) begin
    if (RSTM) begin
      m_p0_q <= '0;
      m_p1_q <= '0;
    end else if (CEM) begin
      m_p0_q <= m_p0_d;
      m_p1_q <= m_p1_d;
    end
  end

  assign M_P0 = M_ON ? m_p0_q : m_p0_d;
  assign M_P1 = M_ON ? m_p1_q : m_p1_d;

endmodule

// File: tb/tb_dual_b_mult_mreg.sv
// Directed bench for dual_b_mult_mreg: three configurations driven from shared stimulus.
module tb_dual_b_mult_mreg;

  logic        CLK = 1'b0;
  logic        RSTB, RSTM, INMODE_4, CEB1, CEB2, CEM;
  logic [17:0] B, BCIN;
  logic [24:0] A_MULT;

  logic [17:0] d_bcout, d_xb, c_bcout, c_xb, o_bcout, o_xb;
  logic [42:0] d_p0, d_p1, c_p0, c_p1, o_p0, o_p1;
  logic [42:0] d_sum, o_sum;

  int n_run  = 0;
  int n_fail = 0;

  assign d_sum = d_p0 + d_p1;
  assign o_sum = o_p0 + o_p1;

  always #5 CLK = ~CLK;

  dual_b_mult_mreg #(.B_INPUT("DIRECT"), .BREG(2), .BCASCREG(1), .MREG(1), .USE_MULT("MULTIPLY"))
  u_dut (.CLK(CLK), .RSTB(RSTB), .RSTM(RSTM), .B(B), .BCIN(BCIN), .A_MULT(A_MULT),
         .INMODE_4(INMODE_4), .CEB1(CEB1), .CEB2(CEB2), .CEM(CEM),
         .BCOUT(d_bcout), .X_MUX_B(d_xb), .M_P0(d_p0), .M_P1(d_p1));

  dual_b_mult_mreg #(.B_INPUT("CASCADE"), .BREG(2), .BCASCREG(1), .MREG(1), .USE_MULT("MULTIPLY"))
  u_casc (.CLK(CLK), .RSTB(RSTB), .RSTM(RSTM), .B(B), .BCIN(BCIN), .A_MULT(A_MULT),
          .INMODE_4(INMODE_4), .CEB1(CEB1), .CEB2(CEB2), .CEM(CEM),
          .BCOUT(c_bcout), .X_MUX_B(c_xb), .M_P0(c_p0), .M_P1(c_p1));

  dual_b_mult_mreg #(.B_INPUT("DIRECT"), .BREG(1), .BCASCREG(1), .MREG(0), .USE_MULT("MULTIPLY"))
  u_one (.CLK(CLK), .RSTB(RSTB), .RSTM(RSTM), .B(B), .BCIN(BCIN), .A_MULT(A_MULT),
         .INMODE_4(INMODE_4), .CEB1(CEB1), .CEB2(CEB2), .CEM(CEM),
         .BCOUT(o_bcout), .X_MUX_B(o_xb), .M_P0(o_p0), .M_P1(o_p1));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RSTB = 1'b1; RSTM = 1'b1; CEB1 = 1'b1; CEB2 = 1'b1; CEM = 1'b1; INMODE_4 = 1'b0;
    B = 18'h00055; BCIN = 18'h00066; A_MULT = 25'd9;
    tick(); tick();
    n_run++; if (d_p0 !== 43'd0) begin n_fail++; $display("FAIL reset_p0: got %h expected 0", d_p0); end
    n_run++; if (d_p1 !== 43'd0) begin n_fail++; $display("FAIL reset_p1: got %h expected 0", d_p1); end
    n_run++; if (d_xb !== 18'd0) begin n_fail++; $display("FAIL reset_xb: got %h expected 0", d_xb); end
    n_run++; if (d_bcout !== 18'd0) begin n_fail++; $display("FAIL reset_bcout: got %h expected 0", d_bcout); end
  endtask

  task automatic test_latency();
    RSTB = 1'b0; RSTM = 1'b0; B = 18'h3FFFF; A_MULT = 25'd5; INMODE_4 = 1'b0;
    tick();
    n_run++; if (o_sum !== 43'h7FFFFFFFFFB) begin n_fail++; $display("FAIL breg1_comb_m: got %h expected 7fffffffffb", o_sum); end
    n_run++; if (o_xb !== 18'h3FFFF) begin n_fail++; $display("FAIL breg1_xb: got %h expected 3ffff", o_xb); end
    n_run++; if (o_bcout !== 18'h3FFFF) begin n_fail++; $display("FAIL breg1_bcout: got %h expected 3ffff", o_bcout); end
    tick();
    n_run++; if (d_sum !== 43'd0) begin n_fail++; $display("FAIL lat3_edge2: got %h expected 0", d_sum); end
    tick();
    n_run++; if (d_sum !== 43'h7FFFFFFFFFB) begin n_fail++; $display("FAIL lat3_edge3: got %h expected 7fffffffffb", d_sum); end
`ifdef DSP_MULT_PARTIAL_PRODUCTS_EN
    n_run++; if (d_p0 !== 43'd2555) begin n_fail++; $display("FAIL neg1_p0: got %h expected %h", d_p0, 43'd2555); end
    n_run++; if (d_p1 !== 43'h7FFFFFFF600) begin n_fail++; $display("FAIL neg1_p1: got %h expected 7fffffff600", d_p1); end
`else
    n_run++; if (d_p0 !== 43'h7FFFFFFFFFB) begin n_fail++; $display("FAIL neg1_p0: got %h expected 7fffffffffb", d_p0); end
    n_run++; if (d_p1 !== 43'd0) begin n_fail++; $display("FAIL neg1_p1: got %h expected 0", d_p1); end
`endif
    RSTB = 1'b1; RSTM = 1'b1;
    tick();
    RSTB = 1'b0; RSTM = 1'b0; INMODE_4 = 1'b1;
    tick();
    n_run++; if (d_sum !== 43'd0) begin n_fail++; $display("FAIL lat2_edge1: got %h expected 0", d_sum); end
    tick();
    n_run++; if (d_sum !== 43'h7FFFFFFFFFB) begin n_fail++; $display("FAIL lat2_edge2: got %h expected 7fffffffffb", d_sum); end
    INMODE_4 = 1'b0;
  endtask

  task automatic test_full_range();
    A_MULT = 25'h1000000; B = 18'h20000;
    tick(); tick(); tick();
    n_run++; if (d_sum !== 43'h20000000000) begin n_fail++; $display("FAIL maxpos_sum: got %h expected 20000000000", d_sum); end
`ifdef DSP_MULT_PARTIAL_PRODUCTS_EN
    n_run++; if (d_p1 !== 43'h20000000000) begin n_fail++; $display("FAIL maxpos_p1: got %h expected 20000000000", d_p1); end
`else
    n_run++; if (d_p1 !== 43'd0) begin n_fail++; $display("FAIL maxpos_p1: got %h expected 0", d_p1); end
`endif
  endtask

  task automatic test_split();
    A_MULT = 25'd3; B = 18'h00201;
    tick(); tick(); tick();
    n_run++; if (d_sum !== 43'd1539) begin n_fail++; $display("FAIL split_sum: got %0d expected 1539", d_sum); end
`ifdef DSP_MULT_PARTIAL_PRODUCTS_EN
    n_run++; if (d_p0 !== 43'd3) begin n_fail++; $display("FAIL split_p0: got %0d expected 3", d_p0); end
    n_run++; if (d_p1 !== 43'd1536) begin n_fail++; $display("FAIL split_p1: got %0d expected 1536", d_p1); end
`else
    n_run++; if (d_p0 !== 43'd1539) begin n_fail++; $display("FAIL split_p0: got %0d expected 1539", d_p0); end
    n_run++; if (d_p1 !== 43'd0) begin n_fail++; $display("FAIL split_p1: got %0d expected 0", d_p1); end
`endif
  endtask

  task automatic test_cascade();
    RSTB = 1'b1;
    tick();
    RSTB = 1'b0; BCIN = 18'h00123; B = 18'h00000;
    tick();
    n_run++; if (c_bcout !== 18'h00123) begin n_fail++; $display("FAIL casc_bcout: got %h expected 00123", c_bcout); end
    n_run++; if (c_xb !== 18'h00000) begin n_fail++; $display("FAIL casc_xb_early: got %h expected 00000", c_xb); end
    tick();
    n_run++; if (c_xb !== 18'h00123) begin n_fail++; $display("FAIL casc_xb: got %h expected 00123", c_xb); end
    n_run++; if (d_xb !== 18'h00000) begin n_fail++; $display("FAIL direct_ignores_bcin: got %h expected 00000", d_xb); end
  endtask

  task automatic test_rstm();
    A_MULT = 25'd6; B = 18'd7;
    tick(); tick(); tick();
    n_run++; if (d_sum !== 43'd42) begin n_fail++; $display("FAIL m42_steady: got %0d expected 42", d_sum); end
    RSTM = 1'b1;
    tick();
    n_run++; if (d_p0 !== 43'd0) begin n_fail++; $display("FAIL rstm_p0: got %h expected 0", d_p0); end
    n_run++; if (d_p1 !== 43'd0) begin n_fail++; $display("FAIL rstm_p1: got %h expected 0", d_p1); end
    RSTM = 1'b0;
    tick();
    n_run++; if (d_sum !== 43'd42) begin n_fail++; $display("FAIL rstm_release: got %0d expected 42", d_sum); end
    RSTB = 1'b1;
    tick();
    n_run++; if (d_xb !== 18'd0) begin n_fail++; $display("FAIL rstb_xb: got %h expected 0", d_xb); end
    n_run++; if (d_bcout !== 18'd0) begin n_fail++; $display("FAIL rstb_bcout: got %h expected 0", d_bcout); end
    n_run++; if (d_sum !== 43'd42) begin n_fail++; $display("FAIL rstb_keeps_m: got %0d expected 42", d_sum); end
    RSTB = 1'b0;
    tick();
    n_run++; if (d_sum !== 43'd0) begin n_fail++; $display("FAIL rstb_zero_product: got %0d expected 0", d_sum); end
  endtask

  task automatic test_ceb2_hold();
    A_MULT = 25'd2; B = 18'd10; INMODE_4 = 1'b0; CEB2 = 1'b1;
    tick(); tick(); tick();
    n_run++; if (d_sum !== 43'd20) begin n_fail++; $display("FAIL hold_setup: got %0d expected 20", d_sum); end
    CEB2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      B = 18'(11 + i);
      tick();
      n_run++; if (d_xb !== 18'd10) begin n_fail++; $display("FAIL hold_xb[%0d]: got %0d expected 10", i, d_xb); end
      n_run++; if (d_sum !== 43'd20) begin n_fail++; $display("FAIL hold_m[%0d]: got %0d expected 20", i, d_sum); end
      n_run++; if (d_bcout !== 18'(11 + i)) begin n_fail++; $display("FAIL hold_b1[%0d]: got %0d expected %0d", i, d_bcout, 11 + i); end
    end
    INMODE_4 = 1'b1;
    tick();
    n_run++; if (d_sum !== 43'd28) begin n_fail++; $display("FAIL hold_b1_mult: got %0d expected 28", d_sum); end
    n_run++; if (d_xb !== 18'd10) begin n_fail++; $display("FAIL hold_xb_final: got %0d expected 10", d_xb); end
    INMODE_4 = 1'b0; CEB2 = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [17:0] bv [5];
    logic [42:0] ev [5];
    bv = '{18'h00001, 18'h3FFFE, 18'h00064, 18'h20000, 18'h1FFFF};
    ev = '{43'd3, 43'h7FFFFFFFFFA, 43'd300, 43'h7FFFFFA0000, 43'd393213};
    A_MULT = 25'd3;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) B = bv[i];
      tick();
      if (i >= 2) begin
        n_run++;
        if (d_sum !== ev[i-2]) begin
          n_fail++; $display("FAIL stream[%0d]: got %h expected %h", i - 2, d_sum, ev[i-2]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full_range();
    test_split();
    test_cascade();
    test_rstm();
    test_ceb2_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
